// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester APB master with round-robin arbitration.
// Each accepted request is sequenced through SETUP/ACCESS. The slave is
// selected by the address MSB. Slave wait states are bounded by TIMEOUT
// ACCESS cycles. Every output comes straight from a register.
//
// Handshake: a requester raises REQ_VALID[i] and holds it and its
// addr/wdata/write stable until REQ_READY[i] pulses, which means the request
// was captured. Later it sees exactly one RSP_VALID[i] pulse carrying
// RSP_RDATA/RSP_ERR. A reset during a transfer aborts it with no response.
module apb_req_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    RST,
    input  logic [1:0]              REQ_VALID,
    input  logic [1:0]              REQ_WRITE,
    input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]              REQ_READY,
    output logic [1:0]              RSP_VALID,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic                    RSP_ERR,
    output logic [1:0]              PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    output logic [1:0]              o_dbg_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Control state
    state_t          r_state, w_state_nx;
    logic            r_ptr, w_ptr_nx;       // requester favoured when both request
    logic            r_gnt, w_gnt_nx;       // requester owning the current transfer
    logic [CW-1:0]   r_cnt, w_cnt_nx;       // ACCESS cycles spent with PREADY low

    // Registered outputs
    logic [1:0]            r_req_ready, w_req_ready_nx;
    logic [1:0]            r_rsp_valid, w_rsp_valid_nx;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nx;
    logic                  r_rsp_err, w_rsp_err_nx;
    logic [1:0]            r_psel, w_psel_nx;
    logic                  r_penable, w_penable_nx;
    logic                  r_pwrite, w_pwrite_nx;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nx;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nx;

    // Selected requester's request fields
    logic                  w_pick;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_write;

    // Round-robin pick: a lone requester wins, otherwise the favoured one
    always_comb begin
        if (REQ_VALID == 2'b11) begin
            w_pick = r_ptr;
        end else begin
            w_pick = ~REQ_VALID[0];
        end
    end

    assign w_sel_addr  = w_pick ? REQ_ADDR[ADDR_WIDTH +: ADDR_WIDTH]  : REQ_ADDR[0 +: ADDR_WIDTH];
    assign w_sel_wdata = w_pick ? REQ_WDATA[DATA_WIDTH +: DATA_WIDTH] : REQ_WDATA[0 +: DATA_WIDTH];
    assign w_sel_write = w_pick ? REQ_WRITE[1] : REQ_WRITE[0];

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer
    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_gnt_nx       = r_gnt;
        w_cnt_nx       = r_cnt;
        w_req_ready_nx = 2'b00;
        w_rsp_valid_nx = 2'b00;
        w_rsp_rdata_nx = r_rsp_rdata;
        w_rsp_err_nx   = r_rsp_err;
        w_psel_nx      = r_psel;
        w_penable_nx   = r_penable;
        w_pwrite_nx    = r_pwrite;
        w_paddr_nx     = r_paddr;
        w_pwdata_nx    = r_pwdata;
        case (r_state)
            ST_IDLE: begin
                if (|REQ_VALID) begin
                    w_gnt_nx       = w_pick;
                    w_ptr_nx       = ~w_pick;
                    w_req_ready_nx = w_pick ? 2'b10 : 2'b01;
                    w_paddr_nx     = w_sel_addr;
                    w_pwdata_nx    = w_sel_wdata;
                    w_pwrite_nx    = w_sel_write;
                    w_psel_nx      = w_sel_addr[ADDR_WIDTH-1] ? 2'b10 : 2'b01;
                    w_penable_nx   = 1'b0;
                    w_cnt_nx       = '0;
                    w_state_nx     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_penable_nx = 1'b1;
                w_state_nx   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_psel_nx      = 2'b00;
                    w_penable_nx   = 1'b0;
                    w_rsp_valid_nx = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_rdata_nx = r_pwrite ? '0 : PRDATA;
                    w_rsp_err_nx   = PSLVERR;
                    w_cnt_nx       = '0;
                    w_state_nx     = ST_IDLE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    // Slave never answered: give up and report an error
                    w_psel_nx      = 2'b00;
                    w_penable_nx   = 1'b0;
                    w_rsp_valid_nx = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_rdata_nx = '0;
                    w_rsp_err_nx   = 1'b1;
                    w_cnt_nx       = '0;
                    w_state_nx     = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_gnt   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_gnt   <= w_gnt_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Output registers
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_req_ready <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 2'b00;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_req_ready <= w_req_ready_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_rdata <= w_rsp_rdata_nx;
            r_rsp_err   <= w_rsp_err_nx;
            r_psel      <= w_psel_nx;
            r_penable   <= w_penable_nx;
            r_pwrite    <= w_pwrite_nx;
            r_paddr     <= w_paddr_nx;
            r_pwdata    <= w_pwdata_nx;
        end
    end

    assign REQ_READY   = r_req_ready;
    assign RSP_VALID   = r_rsp_valid;
    assign RSP_RDATA   = r_rsp_rdata;
    assign RSP_ERR     = r_rsp_err;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: scenario tasks for apb_req_arbiter. The reference model
// is transaction level: a round-robin favoured index plus closed-form
// expectations for latency, response data and error.
module tb_apb_req_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            PCLK;
    logic            RST;
    logic [1:0]      REQ_VALID;
    logic [1:0]      REQ_WRITE;
    logic [2*AW-1:0] REQ_ADDR;
    logic [2*DW-1:0] REQ_WDATA;
    logic [1:0]      REQ_READY;
    logic [1:0]      RSP_VALID;
    logic [DW-1:0]   RSP_RDATA;
    logic            RSP_ERR;
    logic [1:0]      PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;
    logic            PSLVERR;
    logic [1:0]      dbg_state;

    apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int n_vec = 0;
    int n_err = 0;

    // reference model: requester favoured when both request
    int m_ptr = 0;
    logic [AW-1:0] cur_addr[2];
    logic [DW-1:0] cur_wdata[2];
    logic          cur_write[2];

    function automatic int model_pick(input logic [1:0] v);
        if (v == 2'b11) return m_ptr;
        else if (v[0]) return 0;
        else return 1;
    endfunction

    // observations of one transfer
    logic [1:0]    ob_ready, ob_psel_s, ob_psel_a, ob_psel_e, ob_rsp_valid;
    logic          ob_pen_s, ob_pen_a, ob_pen_e, ob_pwrite, ob_err;
    logic [AW-1:0] ob_paddr;
    logic [DW-1:0] ob_pwdata, ob_rdata;
    int            ob_idle, ob_access;
    bit            ob_stable, ob_hung;

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        REQ_WRITE[i] = wr;
        REQ_ADDR[i*AW +: AW] = a;
        REQ_WDATA[i*DW +: DW] = d;
        cur_addr[i] = a;
        cur_wdata[i] = d;
        cur_write[i] = wr;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ_VALID = 2'b00;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        repeat (2) @(negedge PCLK);
        RST = 1'b0;
        m_ptr = 0;
    endtask

    // driver: called at a negedge with REQ_VALID set; runs grant, SETUP and
    // ACCESS, acting as the slave, and records what the bus showed.
    task automatic run_xfer(input int waits, input bit slverr, input logic [DW-1:0] prdata, input bit drop);
        ob_ready = 2'b00; ob_idle = 0; ob_access = 0; ob_rsp_valid = 2'b00;
        ob_stable = 1'b1; ob_hung = 1'b0;
        while (ob_ready == 2'b00 && ob_idle < 20) begin
            @(posedge PCLK); @(negedge PCLK);
            ob_idle++;
            ob_ready = REQ_READY;
        end
        if (ob_ready == 2'b00) begin
            ob_hung = 1'b1;
            return;
        end
        ob_psel_s = PSEL; ob_pen_s = PENABLE; ob_paddr = PADDR; ob_pwdata = PWDATA; ob_pwrite = PWRITE;
        if (drop) REQ_VALID = REQ_VALID & ~ob_ready;
        @(posedge PCLK); @(negedge PCLK);
        ob_psel_a = PSEL; ob_pen_a = PENABLE;
        if (PADDR !== ob_paddr || PWDATA !== ob_pwdata || PWRITE !== ob_pwrite) ob_stable = 1'b0;
        while (ob_rsp_valid == 2'b00 && ob_access < 40) begin
            PREADY  = (ob_access >= waits);
            PSLVERR = slverr & PREADY;
            PRDATA  = prdata;
            @(posedge PCLK); @(negedge PCLK);
            ob_access++;
            ob_rsp_valid = RSP_VALID;
            if (!$onehot0(PSEL)) ob_stable = 1'b0;
            if (ob_rsp_valid == 2'b00 &&
                (PSEL !== ob_psel_s || PENABLE !== 1'b1 || PADDR !== ob_paddr || PWRITE !== ob_pwrite))
                ob_stable = 1'b0;
        end
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        ob_psel_e = PSEL; ob_pen_e = PENABLE; ob_rdata = RSP_RDATA; ob_err = RSP_ERR;
        if (ob_rsp_valid == 2'b00) ob_hung = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        REQ_VALID = 2'b00; REQ_WRITE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK);
        n_vec++; if (REQ_READY !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got %b exp 00", REQ_READY); end
        n_vec++; if (RSP_VALID !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 00", RSP_VALID); end
        n_vec++; if (PSEL !== 2'b00 || PENABLE !== 1'b0) begin n_err++; $display("FAIL rst_psel_pen got %b/%b exp 00/0", PSEL, PENABLE); end
        n_vec++; if ({RSP_RDATA, RSP_ERR, PWRITE, PADDR, PWDATA} !== '0) begin n_err++; $display("FAIL rst_data got %h/%b/%b/%h/%h exp zeros", RSP_RDATA, RSP_ERR, PWRITE, PADDR, PWDATA); end
        RST = 1'b0;
        m_ptr = 0;
        @(negedge PCLK);
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 9'h001, 8'hA5);
        REQ_VALID = 2'b01;
        run_xfer(0, 1'b0, 8'($urandom), 1'b1);
        m_ptr = 1;
        n_vec++; if (ob_hung !== 1'b0) begin n_err++; $display("FAIL wr_hung got %b exp 0", ob_hung); end
        n_vec++; if (ob_ready !== 2'b01 || ob_idle !== 1) begin n_err++; $display("FAIL wr_ready got %b after %0d exp 01 after 1", ob_ready, ob_idle); end
        n_vec++; if (ob_psel_s !== 2'b01 || ob_pen_s !== 1'b0) begin n_err++; $display("FAIL wr_setup got psel %b pen %b exp 01 0", ob_psel_s, ob_pen_s); end
        n_vec++; if (ob_paddr !== 9'h001 || ob_pwdata !== 8'hA5 || ob_pwrite !== 1'b1) begin n_err++; $display("FAIL wr_bus got %h %h %b exp 001 a5 1", ob_paddr, ob_pwdata, ob_pwrite); end
        n_vec++; if (ob_psel_a !== 2'b01 || ob_pen_a !== 1'b1) begin n_err++; $display("FAIL wr_access got psel %b pen %b exp 01 1", ob_psel_a, ob_pen_a); end
        n_vec++; if (ob_access !== 1 || ob_rsp_valid !== 2'b01) begin n_err++; $display("FAIL wr_rsp got %0d cyc valid %b exp 1 01", ob_access, ob_rsp_valid); end
        n_vec++; if (ob_err !== 1'b0 || ob_rdata !== 8'h00) begin n_err++; $display("FAIL wr_rsp_data got err %b rdata %h exp 0 00", ob_err, ob_rdata); end
        n_vec++; if (ob_psel_e !== 2'b00 || ob_pen_e !== 1'b0 || ob_stable !== 1'b1) begin n_err++; $display("FAIL wr_end got psel %b pen %b stable %b exp 00 0 1", ob_psel_e, ob_pen_e, ob_stable); end
    endtask

    task automatic test_single_read();
        set_req(1, 1'b0, 9'h102, 8'($urandom));
        REQ_VALID = 2'b10;
        run_xfer(0, 1'b0, 8'h5A, 1'b1);
        m_ptr = 0;
        n_vec++; if (ob_ready !== 2'b10) begin n_err++; $display("FAIL rd_ready got %b exp 10", ob_ready); end
        n_vec++; if (ob_psel_s !== 2'b10 || ob_pwrite !== 1'b0 || ob_paddr !== 9'h102) begin n_err++; $display("FAIL rd_setup got psel %b pwrite %b paddr %h exp 10 0 102", ob_psel_s, ob_pwrite, ob_paddr); end
        n_vec++; if (ob_rsp_valid !== 2'b10 || ob_rdata !== 8'h5A || ob_err !== 1'b0) begin n_err++; $display("FAIL rd_rsp got %b %h %b exp 10 5a 0", ob_rsp_valid, ob_rdata, ob_err); end
    endtask

    task automatic test_round_robin();
        int g;
        logic [1:0] e_ready;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] prd;
        do_reset();
        @(negedge PCLK);
        set_req(0, 1'($urandom), 9'($urandom), 8'($urandom));
        set_req(1, 1'($urandom), 9'($urandom), 8'($urandom));
        REQ_VALID = 2'b11;
        for (int t = 0; t < 4; t++) begin
            g = model_pick(2'b11);
            e_ready = 2'b01 << g;
            e_addr = cur_addr[g];
            prd = 8'($urandom);
            run_xfer(0, 1'b0, prd, 1'b0);
            n_vec++; if (ob_ready !== e_ready || ob_idle !== 1) begin n_err++; $display("FAIL rr_grant%0d got %b after %0d exp %b after 1", t, ob_ready, ob_idle, e_ready); end
            n_vec++; if (ob_paddr !== e_addr || ob_psel_s !== (2'b01 << e_addr[AW-1])) begin n_err++; $display("FAIL rr_bus%0d got %h %b exp %h", t, ob_paddr, ob_psel_s, e_addr); end
            n_vec++; if (ob_rsp_valid !== e_ready || ob_stable !== 1'b1) begin n_err++; $display("FAIL rr_rsp%0d got %b stable %b exp %b 1", t, ob_rsp_valid, ob_stable, e_ready); end
            m_ptr = 1 - g;
            set_req(g, 1'($urandom), 9'($urandom), 8'($urandom));
        end
        REQ_VALID = 2'b00;
    endtask

    task automatic test_wait_err();
        set_req(0, 1'b0, 9'($urandom), 8'($urandom));
        REQ_VALID = 2'b01;
        run_xfer(3, 1'b1, 8'h3C, 1'b1);
        m_ptr = 1;
        n_vec++; if (ob_access !== 4) begin n_err++; $display("FAIL we_access got %0d exp 4", ob_access); end
        n_vec++; if (ob_rsp_valid !== 2'b01 || ob_err !== 1'b1 || ob_rdata !== 8'h3C) begin n_err++; $display("FAIL we_rsp got %b %b %h exp 01 1 3c", ob_rsp_valid, ob_err, ob_rdata); end
        n_vec++; if (ob_stable !== 1'b1) begin n_err++; $display("FAIL we_stable got %b exp 1", ob_stable); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] prd;
        set_req(1, 1'b0, 9'($urandom), 8'($urandom));
        REQ_VALID = 2'b10;
        run_xfer(1000, 1'b0, 8'hFF, 1'b1);
        m_ptr = 0;
        n_vec++; if (ob_access !== TO) begin n_err++; $display("FAIL to_access got %0d exp %0d", ob_access, TO); end
        n_vec++; if (ob_rsp_valid !== 2'b10 || ob_err !== 1'b1 || ob_rdata !== 8'h00) begin n_err++; $display("FAIL to_rsp got %b %b %h exp 10 1 00", ob_rsp_valid, ob_err, ob_rdata); end
        n_vec++; if (ob_psel_e !== 2'b00 || ob_pen_e !== 1'b0) begin n_err++; $display("FAIL to_end got %b %b exp 00 0", ob_psel_e, ob_pen_e); end
        prd = 8'($urandom);
        set_req(0, 1'b0, 9'($urandom), 8'($urandom));
        REQ_VALID = 2'b01;
        run_xfer(0, 1'b0, prd, 1'b1);
        m_ptr = 1;
        n_vec++; if (ob_ready !== 2'b01 || ob_idle !== 1 || ob_access !== 1) begin n_err++; $display("FAIL to_next got %b %0d %0d exp 01 1 1", ob_ready, ob_idle, ob_access); end
        n_vec++; if (ob_err !== 1'b0 || ob_rdata !== prd) begin n_err++; $display("FAIL to_next_rsp got %b %h exp 0 %h", ob_err, ob_rdata, prd); end
    endtask

    task automatic test_idle_no_req();
        int g;
        REQ_VALID = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(posedge PCLK); @(negedge PCLK);
            n_vec++; if (REQ_READY !== 2'b00 || PSEL !== 2'b00 || RSP_VALID !== 2'b00) begin n_err++; $display("FAIL idle%0d got %b %b %b exp 00 00 00", c, REQ_READY, PSEL, RSP_VALID); end
        end
        g = model_pick(2'b11);
        REQ_VALID = 2'b11;
        run_xfer(0, 1'b0, 8'($urandom), 1'b1);
        m_ptr = 1 - g;
        REQ_VALID = 2'b00;
        n_vec++; if (ob_ready !== (2'b01 << g)) begin n_err++; $display("FAIL idle_ptr got %b exp %b", ob_ready, 2'b01 << g); end
    endtask

    task automatic test_random();
        logic [1:0] v, e_ready;
        int g, waits;
        bit slv, tmo;
        logic [DW-1:0] prd, e_rdata;
        for (int t = 0; t < 20; t++) begin
            v = 2'($urandom_range(1, 3));
            set_req(0, 1'($urandom), 9'($urandom), 8'($urandom));
            set_req(1, 1'($urandom), 9'($urandom), 8'($urandom));
            waits = $urandom_range(0, 5);
            if (waits == 5) waits = TO - 1;
            slv = 1'($urandom);
            prd = 8'($urandom);
            g = model_pick(v);
            e_ready = 2'b01 << g;
            tmo = (waits >= TO);
            e_rdata = (tmo || cur_write[g]) ? 8'h00 : prd;
            REQ_VALID = v;
            run_xfer(waits, slv, prd, 1'b1);
            REQ_VALID = 2'b00;
            m_ptr = 1 - g;
            n_vec++; if (ob_ready !== e_ready) begin n_err++; $display("FAIL rnd%0d_grant got %b exp %b", t, ob_ready, e_ready); end
            n_vec++; if (ob_paddr !== cur_addr[g] || ob_pwdata !== cur_wdata[g] || ob_pwrite !== cur_write[g] || ob_psel_s !== (2'b01 << cur_addr[g][AW-1]))
                begin n_err++; $display("FAIL rnd%0d_bus got %h %h %b %b exp %h %h %b", t, ob_paddr, ob_pwdata, ob_pwrite, ob_psel_s, cur_addr[g], cur_wdata[g], cur_write[g]); end
            n_vec++; if (ob_access !== (tmo ? TO : waits + 1)) begin n_err++; $display("FAIL rnd%0d_access got %0d exp %0d", t, ob_access, tmo ? TO : waits + 1); end
            n_vec++; if (ob_rsp_valid !== e_ready || ob_rdata !== e_rdata || ob_err !== (tmo | slv))
                begin n_err++; $display("FAIL rnd%0d_rsp got %b %h %b exp %b %h %b", t, ob_rsp_valid, ob_rdata, ob_err, e_ready, e_rdata, tmo | slv); end
            n_vec++; if (ob_stable !== 1'b1) begin n_err++; $display("FAIL rnd%0d_stable got %b exp 1", t, ob_stable); end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        set_req(0, 1'b1, 9'($urandom), 8'($urandom));
        REQ_VALID = 2'b01;
        run_xfer(0, 1'b0, 8'h00, 1'b1);
        m_ptr = 1;
        set_req(1, 1'b0, 9'($urandom), 8'($urandom));
        REQ_VALID = 2'b10;
        c = 0;
        while (REQ_READY == 2'b00 && c < 20) begin
            @(posedge PCLK); @(negedge PCLK);
            c++;
        end
        REQ_VALID = 2'b00;
        PREADY = 1'b0;
        repeat (2) begin @(posedge PCLK); @(negedge PCLK); end
        n_vec++; if (PENABLE !== 1'b1 || PSEL !== (2'b01 << cur_addr[1][AW-1])) begin n_err++; $display("FAIL mid_access got pen %b psel %b exp 1", PENABLE, PSEL); end
        RST = 1'b1;
        #1;
        n_vec++; if (PSEL !== 2'b00 || PENABLE !== 1'b0 || RSP_VALID !== 2'b00) begin n_err++; $display("FAIL mid_rst got %b %b %b exp 00 0 00", PSEL, PENABLE, RSP_VALID); end
        @(posedge PCLK); @(negedge PCLK);
        RST = 1'b0;
        m_ptr = 0;
        set_req(0, 1'($urandom), 9'($urandom), 8'($urandom));
        set_req(1, 1'($urandom), 9'($urandom), 8'($urandom));
        REQ_VALID = 2'b11;
        run_xfer(0, 1'b0, 8'($urandom), 1'b1);
        REQ_VALID = 2'b00;
        n_vec++; if (ob_ready !== 2'b01 || ob_idle !== 1) begin n_err++; $display("FAIL mid_regrant got %b after %0d exp 01 after 1", ob_ready, ob_idle); end
        n_vec++; if (ob_rsp_valid !== 2'b01) begin n_err++; $display("FAIL mid_rsp got %b exp 01", ob_rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_wait_err();
        test_timeout();
        test_idle_no_req();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
